pll_lock_supervisor: RTL and testbench

Supervises a PLL and its lock indicator, and releases the system reset only after lock has been stable for a programmable time. It drives the PLL reset input, synchronises the asynchronous `pll_lock` output, re-pulses the PLL reset if lock is not acquired within a timeout, and counts lock-loss events. It sits directly around the PLL instance, in the reference-clock domain, and feeds the reset tree of all downstream logic.

---
 rtl/pll_lock_supervisor.sv | 165 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// pll_lock_supervisor
//   Sits around a PLL in the reference-clock domain. It holds the PLL in reset
//   for a fixed pulse, waits for the synchronised lock flag to stay high for
//   LOCK_STABLE_CYC cycles, and only then releases the downstream system reset.
//   If lock is not reached within LOCK_TIMEOUT_CYC cycles, the PLL is reset again.
//   When lock is lost while running, the system is put back into reset and the
//   loss is counted.
//
// Ports
//   clk          in   free-running reference clock (PLL input clock)
//   rst_n        in   asynchronous active-low reset
//   pll_lock     in   PLL lock flag, asynchronous to clk
//   pll_rst      out  active-high PLL reset (registered)
//   sys_rst_n    out  active-low system reset, high only in RUN (registered)
//   lock_err     out  one-cycle pulse per lock loss while running
//   lock_timeout out  sticky flag, set on the first acquisition timeout
//   loss_cnt     out  saturating lock-loss counter
//   fsm_state    out  current state encoding, for debug
module pll_lock_supervisor #(
  parameter int unsigned LOCK_STABLE_CYC  = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 100000,
  parameter int unsigned RST_PULSE_CYC    = 8,
  parameter int unsigned LOSS_CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  lock_err,
  output logic                  lock_timeout,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output logic [2:0]            fsm_state
);

  localparam int unsigned RST_W = (RST_PULSE_CYC    > 1) ? $clog2(RST_PULSE_CYC)    : 1;
  localparam int unsigned STB_W = (LOCK_STABLE_CYC  > 1) ? $clog2(LOCK_STABLE_CYC)  : 1;
  localparam int unsigned TMO_W = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_PULSE_CYC - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_PLL_RST = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RUN     = 3'd3,
    ST_LOST    = 3'd4
  } state_t;

  state_t                state_q;
  logic                  sync1_q;
  logic                  lock_sync_q;
  logic                  pll_rst_q;
  logic                  sys_rst_n_q;
  logic                  lock_err_q;
  logic                  lock_timeout_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic [RST_W-1:0]      rst_cnt_q;
  logic [STB_W-1:0]      stable_cnt_q;
  logic [TMO_W-1:0]      tmo_cnt_q;

  logic settle_done;
  logic tmo_hit;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      sync1_q     <= pll_lock;
      lock_sync_q <= sync1_q;
    end
  end

  assign settle_done = (state_q == ST_SETTLE) && lock_sync_q && (stable_cnt_q == STB_LAST);
  assign tmo_hit     = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_PLL_RST;
      pll_rst_q      <= 1'b1;
      sys_rst_n_q    <= 1'b0;
      lock_err_q     <= 1'b0;
      lock_timeout_q <= 1'b0;
      loss_cnt_q     <= '0;
      rst_cnt_q      <= '0;
      stable_cnt_q   <= '0;
      tmo_cnt_q      <= '0;
    end else begin
      lock_err_q <= 1'b0;
      case (state_q)
        ST_PLL_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q   <= ST_ACQUIRE;
            tmo_cnt_q <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end

        // ACQUIRE and SETTLE share the timeout window; completing SETTLE
        // takes priority over a timeout falling on the same edge.
        ST_ACQUIRE, ST_SETTLE: begin
          if (settle_done) begin
            state_q     <= ST_RUN;
            sys_rst_n_q <= 1'b1;
          end else if (tmo_hit) begin
            state_q        <= ST_PLL_RST;
            rst_cnt_q      <= '0;
            pll_rst_q      <= 1'b1;
            lock_timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (state_q == ST_ACQUIRE) begin
              if (lock_sync_q) begin
                state_q      <= ST_SETTLE;
                stable_cnt_q <= '0;
              end
            end else if (!lock_sync_q) begin
              state_q <= ST_ACQUIRE;
            end else begin
              stable_cnt_q <= stable_cnt_q + 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (!lock_sync_q) begin
            state_q     <= ST_LOST;
            sys_rst_n_q <= 1'b0;
            lock_err_q  <= 1'b1;
            if (loss_cnt_q != '1) begin
              loss_cnt_q <= loss_cnt_q + 1'b1;
            end
          end
        end

        ST_LOST: begin
          state_q   <= ST_ACQUIRE;
          tmo_cnt_q <= '0;
        end

        default: begin
          state_q     <= ST_PLL_RST;
          rst_cnt_q   <= '0;
          pll_rst_q   <= 1'b1;
          sys_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst_n    = sys_rst_n_q;
  assign lock_err     = lock_err_q;
  assign lock_timeout = lock_timeout_q;
  assign loss_cnt     = loss_cnt_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
// Testbench for pll_lock_supervisor. A reference model predicts output
// transition events (signal, value, edge number) from the pll_lock waveform;
// a monitor detects DUT output transitions and matches them against the queue.
module tb_pll_lock_supervisor;

  localparam int S = 16;
  localparam int T = 100;
  localparam int P = 8;
  localparam int W = 2;

  localparam int K_PLLRST = 0;
  localparam int K_SYS    = 1;
  localparam int K_ERR    = 2;
  localparam int K_LOSS   = 3;
  localparam int K_TMO    = 4;

  localparam int M_RESET = 0;
  localparam int M_ACQ   = 1;
  localparam int M_RUN   = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pll_lock;
  logic         pll_rst;
  logic         sys_rst_n;
  logic         lock_err;
  logic         lock_timeout;
  logic [W-1:0] loss_cnt;
  logic [2:0]   fsm_state;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .LOCK_STABLE_CYC (S),
    .LOCK_TIMEOUT_CYC(T),
    .RST_PULSE_CYC   (P),
    .LOSS_CNT_W      (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .lock_err    (lock_err),
    .lock_timeout(lock_timeout),
    .loss_cnt    (loss_cnt),
    .fsm_state   (fsm_state)
  );

  typedef struct {
    int cyc;
    int kind;
    int val;
  } evt_t;

  evt_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  int sys_rise_cyc   = -1;
  int err_rise_cyc   = -1;
  int pllrst_fall    = -1;
  int err_rises      = 0;
  int pllrst_rises   = 0;

  // model state
  bit l1, l2;
  bit m_tmo;
  int m_mode, m_e, m_e0, m_hr, m_loss;

  function automatic string kname(int k);
    case (k)
      K_PLLRST: return "pll_rst";
      K_SYS:    return "sys_rst_n";
      K_ERR:    return "lock_err";
      K_LOSS:   return "loss_cnt";
      default:  return "lock_timeout";
    endcase
  endfunction

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Insert keeping (edge, kind) order, which is the order the monitor observes.
  function automatic void push(int c, int k, int v);
    evt_t e;
    int   i;
    e.cyc = c; e.kind = k; e.val = v;
    i = 0;
    while (i < expq.size() && (expq[i].cyc < c || (expq[i].cyc == c && expq[i].kind <= k)))
      i++;
    expq.insert(i, e);
  endfunction

  function automatic void model_reset();
    m_mode = M_RESET; m_e = 0; m_e0 = 0; m_hr = 0;
    l1 = 1'b0; l2 = 1'b0; m_tmo = 1'b0; m_loss = 0;
  endfunction

  // Behaviour per edge: the supervisor sees pll_lock two edges late. It leaves
  // reset P edges after entering it; it releases the system once it has seen
  // S+1 consecutive high samples inside the acquisition window; the window
  // expires T edges after it opened; a low sample while running is a loss and
  // the window reopens one edge later.
  function automatic void model_edge(bit lvl);
    bit s;
    s = l2; l2 = l1; l1 = lvl;
    case (m_mode)
      M_RESET: begin
        if (cyc == m_e + P) begin
          push(cyc, K_PLLRST, 0);
          m_mode = M_ACQ; m_e0 = cyc; m_hr = 0;
        end
      end
      M_ACQ: begin
        if (cyc > m_e0) begin
          m_hr = s ? m_hr + 1 : 0;
          if (m_hr == S + 1) begin
            push(cyc, K_SYS, 1);
            m_mode = M_RUN;
          end else if (cyc - m_e0 == T) begin
            push(cyc, K_PLLRST, 1);
            if (!m_tmo) push(cyc, K_TMO, 1);
            m_tmo = 1'b1;
            m_mode = M_RESET; m_e = cyc;
          end
        end
      end
      default: begin
        if (!s) begin
          push(cyc, K_SYS, 0);
          push(cyc, K_ERR, 1);
          if (m_loss < (1 << W) - 1) begin
            m_loss++;
            push(cyc, K_LOSS, m_loss);
          end
          push(cyc + 1, K_ERR, 0);
          m_mode = M_ACQ; m_e0 = cyc + 1; m_hr = 0;
        end
      end
    endcase
  endfunction

  function automatic void obs(int kind, int val);
    evt_t e;
    n_checks++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got %0d at edge %0d, expected no change", kname(kind), val, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event_%s: got %s=%0d at edge %0d, expected %s=%0d at edge %0d",
                 kname(kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endfunction

  logic         p_pll_rst, p_sys, p_err, p_tmo;
  logic [W-1:0] p_loss;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL missed_%s: got no change, expected %0d at edge %0d",
                   kname(expq[0].kind), expq[0].val, expq[0].cyc);
          expq.delete(0);
        end
        if (pll_rst !== p_pll_rst) begin
          obs(K_PLLRST, int'(pll_rst));
          if (pll_rst) pllrst_rises++; else pllrst_fall = cyc;
        end
        if (sys_rst_n !== p_sys) begin
          obs(K_SYS, int'(sys_rst_n));
          if (sys_rst_n) sys_rise_cyc = cyc;
        end
        if (lock_err !== p_err) begin
          obs(K_ERR, int'(lock_err));
          if (lock_err) begin err_rises++; err_rise_cyc = cyc; end
        end
        if (loss_cnt !== p_loss) obs(K_LOSS, int'(loss_cnt));
        if (lock_timeout !== p_tmo) obs(K_TMO, int'(lock_timeout));
      end
      p_pll_rst = pll_rst; p_sys = sys_rst_n; p_err = lock_err;
      p_loss = loss_cnt; p_tmo = lock_timeout;
    end
  end

  // Called at a rising edge; drives the level at the following falling edge
  // so it is sampled by the next rising edge.
  task automatic step(bit lvl);
    @(negedge clk);
    pll_lock = lvl;
    @(posedge clk);
    cyc++;
    model_edge(lvl);
  endtask

  task automatic hold(bit lvl, int n);
    repeat (n) step(lvl);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    mon_en = 1'b1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_pll_rst"},      int'(pll_rst),      1);
    check({tag, "_sys_rst_n"},    int'(sys_rst_n),    0);
    check({tag, "_lock_err"},     int'(lock_err),     0);
    check({tag, "_lock_timeout"}, int'(lock_timeout), 0);
    check({tag, "_loss_cnt"},     int'(loss_cnt),     0);
    check({tag, "_fsm_state"},    int'(fsm_state),    0);
  endtask

  int c0;
  int r0;
  int exp_loss[4] = '{1, 2, 3, 3};

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    #12;
    check_reset_outputs("reset");

    // Clean bring-up
    release_reset();
    hold(1'b0, 20);
    check("bringup_pll_rst_fall_edge", pllrst_fall, P);
    c0 = cyc;
    hold(1'b1, 30);
    #2;
    check("bringup_release_edge", sys_rise_cyc, c0 + S + 3);
    check("bringup_state", int'(fsm_state), 3);
    check("bringup_loss_cnt", int'(loss_cnt), 0);
    check("bringup_timeout", int'(lock_timeout), 0);

    // Lock loss in RUN, then re-lock
    c0 = cyc;
    hold(1'b0, 5);
    #2;
    check("loss_err_edge", err_rise_cyc, c0 + 3);
    check("loss_cnt_1", int'(loss_cnt), 1);
    c0 = cyc;
    hold(1'b1, 30);
    #2;
    check("relock_release_edge", sys_rise_cyc, c0 + S + 3);

    // Second loss, then a 2-cycle glitch 10 cycles into SETTLE
    hold(1'b0, 5);
    r0 = err_rises;
    hold(1'b1, 12);
    hold(1'b0, 2);
    c0 = cyc;
    hold(1'b1, 30);
    #2;
    check("glitch_release_edge", sys_rise_cyc, c0 + S + 3);
    check("glitch_no_err", err_rises - r0, 0);
    check("glitch_loss_cnt", int'(loss_cnt), 2);
    check("glitch_state", int'(fsm_state), 3);

    // Async reset between edges while running with loss_cnt=2
    check("pre_reset_queue_empty", expq.size(), 0);
    mon_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (2) @(posedge clk);
    release_reset();

    // Loss counter saturation
    hold(1'b0, 12);
    hold(1'b1, 25);
    r0 = err_rises;
    for (int i = 0; i < 4; i++) begin
      hold(1'b0, 4);
      hold(1'b1, 25);
      #2;
      check("sat_loss_cnt", int'(loss_cnt), exp_loss[i]);
    end
    check("sat_err_pulses", err_rises - r0, 4);

    // Never locks: periodic PLL re-pulses
    r0 = pllrst_rises;
    hold(1'b0, 3 * (T + P) + 40);
    #2;
    check("timeout_repulses", pllrst_rises - r0, 3);
    check("timeout_sticky", int'(lock_timeout), 1);
    hold(1'b1, 30);
    #2;
    check("timeout_relock_state", int'(fsm_state), 3);
    check("timeout_still_sticky", int'(lock_timeout), 1);

    // Random lock waveform
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)
        hold(1'($urandom_range(0, 1)), int'($urandom_range(100, 140)));
      else
        hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
    end
    hold(1'b1, 40);
    #2;
    check("final_queue_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
